// File: rtl/fft_pkg.sv
// Shared constants and types for the final radix-2 combine of the 32-point FFT.
// Twiddle ROM holds W^k = exp(-j*2*pi*k/32) for k = 0..15 in signed Q2.14.
package fft_pkg;

    localparam int TOTAL_BITS = 32;
    localparam int TW_BITS    = 16;
    localparam int TW_FRAC    = 14;
    localparam int N_HALF     = 16;
    localparam int PROD_W     = TOTAL_BITS + TW_BITS;
    localparam int FULL_W     = PROD_W + 1;
    localparam int SUM_W      = TOTAL_BITS + 2;

    localparam logic signed [TOTAL_BITS-1:0] SAT_MAX = {1'b0, {(TOTAL_BITS-1){1'b1}}};
    localparam logic signed [TOTAL_BITS-1:0] SAT_MIN = {1'b1, {(TOTAL_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [TOTAL_BITS-1:0] re;
        logic signed [TOTAL_BITS-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [TW_BITS-1:0] re;
        logic signed [TW_BITS-1:0] im;
    } tw_t;

    localparam tw_t TW_ROM [N_HALF] = '{
        '{ 16'sd16384,  16'sd0    },
        '{ 16'sd16069, -16'sd3196 },
        '{ 16'sd15137, -16'sd6270 },
        '{ 16'sd13623, -16'sd9102 },
        '{ 16'sd11585, -16'sd11585},
        '{ 16'sd9102,  -16'sd13623},
        '{ 16'sd6270,  -16'sd15137},
        '{ 16'sd3196,  -16'sd16069},
        '{ 16'sd0,     -16'sd16384},
        '{-16'sd3196,  -16'sd16069},
        '{-16'sd6270,  -16'sd15137},
        '{-16'sd9102,  -16'sd13623},
        '{-16'sd11585, -16'sd11585},
        '{-16'sd13623, -16'sd9102 },
        '{-16'sd15137, -16'sd6270 },
        '{-16'sd16069, -16'sd3196 }
    };

    function automatic logic sat_hit(input logic signed [SUM_W-1:0] x);
        return (x > SUM_W'(SAT_MAX)) || (x < SUM_W'(SAT_MIN));
    endfunction

    function automatic logic signed [TOTAL_BITS-1:0] sat_val(input logic signed [SUM_W-1:0] x);
        if (x > SUM_W'(SAT_MAX)) return SAT_MAX;
        if (x < SUM_W'(SAT_MIN)) return SAT_MIN;
        return TOTAL_BITS'(x);
    endfunction

endpackage

// File: rtl/cmplx_mult_tw.sv
// Two-stage pipelined complex multiply O*W with round-half-up shift by TW_FRAC.
// Stage 1 registers the operands, stage 2 the four partial products.
module cmplx_mult_tw
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  cplx_t                   o_i,
    input  tw_t                     w_i,
    output logic signed [SUM_W-1:0] p_re_o,
    output logic signed [SUM_W-1:0] p_im_o
);

    localparam logic signed [FULL_W-1:0] RND_HALF = FULL_W'(1) <<< (TW_FRAC - 1);

    cplx_t                    o_q;
    tw_t                      w_q;
    logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [FULL_W-1:0] full_re, full_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q  <= '0;
            w_q  <= '0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
        end else if (en_i) begin
            o_q  <= o_i;
            w_q  <= w_i;
            rr_q <= PROD_W'($signed(o_q.re)) * PROD_W'($signed(w_q.re));
            ii_q <= PROD_W'($signed(o_q.im)) * PROD_W'($signed(w_q.im));
            ri_q <= PROD_W'($signed(o_q.re)) * PROD_W'($signed(w_q.im));
            ir_q <= PROD_W'($signed(o_q.im)) * PROD_W'($signed(w_q.re));
        end
    end

    assign full_re = FULL_W'(rr_q) - FULL_W'(ii_q);
    assign full_im = FULL_W'(ri_q) + FULL_W'(ir_q);

    // |W| <= 1 keeps the rounded product within SUM_W, so the narrowing is lossless.
    assign p_re_o = SUM_W'((full_re + RND_HALF) >>> TW_FRAC);
    assign p_im_o = SUM_W'((full_im + RND_HALF) >>> TW_FRAC);

endmodule

// File: rtl/fft_combine_stage.sv
// Final radix-2 combine: X[k] = E[k] + W^k O[k], X[k+16] = E[k] - W^k O[k],
// streamed out in natural order with a 3-cycle read-to-result pipeline.
module fft_combine_stage
    import fft_pkg::*;
(
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         ED,
    input  logic                         START,
    output logic [3:0]                   ADDR,
    input  logic signed [TOTAL_BITS-1:0] EReal,
    input  logic signed [TOTAL_BITS-1:0] EImag,
    input  logic signed [TOTAL_BITS-1:0] OReal,
    input  logic signed [TOTAL_BITS-1:0] OImag,
    output logic signed [TOTAL_BITS-1:0] DOReal,
    output logic signed [TOTAL_BITS-1:0] DOImag,
    output logic                         RDY,
    output logic                         DONE,
    output logic                         BUSY,
    output logic                         OVF
);

    state_t                       state_q;
    logic [4:0]                   n_q;
    logic                         ovf_q;
    logic [3:1]                   vld_pipe_q, last_pipe_q;
    logic [2:1]                   sub_pipe_q;
    cplx_t                        e1_q, e2_q, o_in;
    logic signed [TOTAL_BITS-1:0] do_re_q, do_im_q, do_re_d, do_im_d;
    logic signed [SUM_W-1:0]      p_re, p_im, sum_re_d, sum_im_d;
    logic                         issue, clamp_d;

    assign issue = (state_q == RUN);
    assign o_in  = '{re: OReal, im: OImag};

    cmplx_mult_tw u_mult (
        .clk    (CLK),
        .rst_n  (RST),
        .en_i   (ED),
        .o_i    (o_in),
        .w_i    (TW_ROM[n_q[3:0]]),
        .p_re_o (p_re),
        .p_im_o (p_im)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (START) begin
                    state_q <= RUN;
                    n_q     <= '0;
                    ovf_q   <= 1'b0;
                end
                RUN: if (ED) begin
                    n_q <= n_q + 5'd1;
                    if (n_q == 5'd31) state_q <= DRAIN;
                end
                // Leave only once DONE has been seen by an enabled cycle.
                DRAIN: if (ED && last_pipe_q[3]) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (ED && vld_pipe_q[2] && clamp_d) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            sub_pipe_q  <= '0;
            e1_q        <= '0;
            e2_q        <= '0;
            do_re_q     <= '0;
            do_im_q     <= '0;
        end else if (ED) begin
            vld_pipe_q  <= {vld_pipe_q[2:1], issue};
            last_pipe_q <= {last_pipe_q[2:1], issue && (n_q == 5'd31)};
            sub_pipe_q  <= {sub_pipe_q[1], n_q[4]};
            e1_q        <= '{re: EReal, im: EImag};
            e2_q        <= e1_q;
            if (vld_pipe_q[2]) begin
                do_re_q <= do_re_d;
                do_im_q <= do_im_d;
            end
        end
    end

    always_comb begin
        sum_re_d = SUM_W'($signed(e2_q.re)) + p_re;
        sum_im_d = SUM_W'($signed(e2_q.im)) + p_im;
        if (sub_pipe_q[2]) begin
            sum_re_d = SUM_W'($signed(e2_q.re)) - p_re;
            sum_im_d = SUM_W'($signed(e2_q.im)) - p_im;
        end
    end

    assign do_re_d = sat_val(sum_re_d);
    assign do_im_d = sat_val(sum_im_d);
    assign clamp_d = sat_hit(sum_re_d) || sat_hit(sum_im_d);

    assign ADDR   = n_q[3:0];
    assign DOReal = do_re_q;
    assign DOImag = do_im_q;
    assign RDY    = vld_pipe_q[3];
    assign DONE   = last_pipe_q[3];
    assign BUSY   = (state_q != IDLE);
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_fft_combine_stage.sv
// Directed and randomized frames for fft_combine_stage, checked against a
// real-arithmetic DFT-combine model with saturation.
module tb_fft_combine_stage;

    logic               CLK, RST, ED, START;
    logic [3:0]         ADDR;
    logic signed [31:0] EReal, EImag, OReal, OImag, DOReal, DOImag;
    logic               RDY, DONE, BUSY, OVF;

    logic signed [31:0] e_re [16], e_im [16], o_re [16], o_im [16];
    longint             exp_re [32], exp_im [32];
    bit                 exp_ovf, prev_ovf;
    int                 checks, errors;

    fft_combine_stage dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START), .ADDR(ADDR),
        .EReal(EReal), .EImag(EImag), .OReal(OReal), .OImag(OImag),
        .DOReal(DOReal), .DOImag(DOImag), .RDY(RDY), .DONE(DONE),
        .BUSY(BUSY), .OVF(OVF)
    );

    assign EReal = e_re[ADDR];
    assign EImag = e_im[ADDR];
    assign OReal = o_re[ADDR];
    assign OImag = o_im[ADDR];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic longint rnd(input real x);
        return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(-x + 0.5));
    endfunction

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) begin exp_ovf = 1'b1; return 64'sd2147483647; end
        if (v < -64'sd2147483648) begin exp_ovf = 1'b1; return -64'sd2147483648; end
        return v;
    endfunction

    function automatic void model();
        real    ang;
        longint wr, wi, pr, pi;
        exp_ovf = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ang = 2.0 * 3.141592653589793 * k / 32.0;
            wr  = rnd(16384.0 * $cos(ang));
            wi  = rnd(-16384.0 * $sin(ang));
            pr  = (longint'(o_re[k]) * wr - longint'(o_im[k]) * wi + 8192) >>> 14;
            pi  = (longint'(o_re[k]) * wi + longint'(o_im[k]) * wr + 8192) >>> 14;
            exp_re[k]      = sat(longint'(e_re[k]) + pr);
            exp_im[k]      = sat(longint'(e_im[k]) + pi);
            exp_re[k + 16] = sat(longint'(e_re[k]) - pr);
            exp_im[k + 16] = sat(longint'(e_im[k]) - pi);
        end
    endfunction

    task automatic clear_ram();
        for (int k = 0; k < 16; k++) begin
            e_re[k] = '0; e_im[k] = '0; o_re[k] = '0; o_im[k] = '0;
        end
    endtask

    task automatic passthrough_ram();
        clear_ram();
        for (int k = 0; k < 16; k++) e_re[k] = 32'(k);
    endtask

    task automatic random_ram(input int shift);
        for (int k = 0; k < 16; k++) begin
            e_re[k] = $signed($urandom) >>> shift; e_im[k] = $signed($urandom) >>> shift;
            o_re[k] = $signed($urandom) >>> shift; o_im[k] = $signed($urandom) >>> shift;
        end
    endtask

    // Cycle 0 carries START; ED is low for cycles [stall_at, stall_at+stall_len).
    task automatic run_frame(input int stall_at, input int stall_len, input int rst_at, input bit start_in_run);
        int cyc, got, first_rdy;
        bit fin;
        got = 0; first_rdy = -1; fin = 1'b0;
        model();
        @(posedge CLK); #1;
        START = 1'b1; ED = 1'b1; cyc = 0;
        while (!fin && cyc < 120) begin
            @(negedge CLK);
            if (cyc == 0) begin
                chk("busy_before", 64'(BUSY), 64'(0));
                chk("ovf_sticky", 64'(OVF), 64'(prev_ovf));
            end
            if (cyc == 1) begin
                chk("busy_run", 64'(BUSY), 64'(1));
                chk("ovf_cleared", 64'(OVF), 64'(0));
                chk("addr_first", 64'(ADDR), 64'(0));
            end
            if (RDY && ED) begin
                if (first_rdy < 0) first_rdy = cyc;
                if (got < 32) begin
                    chk("x_re", 64'(DOReal), exp_re[got]);
                    chk("x_im", 64'(DOImag), exp_im[got]);
                end
                got++;
                chk("done_flag", 64'(DONE), 64'(got == 32));
                if (got >= 32) begin
                    fin = 1'b1;
                    chk("first_rdy_cycle", 64'(first_rdy), 64'(4));
                    chk("done_cycle", 64'(cyc), 64'(35 + stall_len));
                    chk("ovf_at_done", 64'(OVF), 64'(exp_ovf));
                    chk("busy_at_done", 64'(BUSY), 64'(1));
                end
            end else if (ED && cyc > 0) begin
                chk("done_without_rdy", 64'(DONE), 64'(0));
            end
            @(posedge CLK); #1;
            cyc++;
            START = start_in_run && (cyc == 10);
            ED    = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (cyc == rst_at) begin
                RST = 1'b0;
                #1;
                chk("rst_addr", 64'(ADDR), 64'(0));
                chk("rst_do_re", 64'(DOReal), 64'(0));
                chk("rst_do_im", 64'(DOImag), 64'(0));
                chk("rst_rdy", 64'(RDY), 64'(0));
                chk("rst_done", 64'(DONE), 64'(0));
                chk("rst_busy", 64'(BUSY), 64'(0));
                chk("rst_ovf", 64'(OVF), 64'(0));
                fin = 1'b1;
            end
        end
        if (!fin) chk("frame_timeout", 64'(0), 64'(1));
        else if (rst_at < 0) begin
            @(negedge CLK);
            chk("idle_busy", 64'(BUSY), 64'(0));
            chk("idle_rdy", 64'(RDY), 64'(0));
            chk("idle_done", 64'(DONE), 64'(0));
            chk("idle_ovf", 64'(OVF), 64'(exp_ovf));
            prev_ovf = exp_ovf;
        end
    endtask

    initial begin
        checks = 0; errors = 0; prev_ovf = 1'b0;
        RST = 1'b0; ED = 1'b0; START = 1'b0;
        clear_ram();
        repeat (2) @(negedge CLK);
        chk("reset_addr", 64'(ADDR), 64'(0));
        chk("reset_do_re", 64'(DOReal), 64'(0));
        chk("reset_do_im", 64'(DOImag), 64'(0));
        chk("reset_rdy", 64'(RDY), 64'(0));
        chk("reset_done", 64'(DONE), 64'(0));
        chk("reset_busy", 64'(BUSY), 64'(0));
        chk("reset_ovf", 64'(OVF), 64'(0));
        @(posedge CLK); #1;
        RST = 1'b1; ED = 1'b1;

        passthrough_ram();
        run_frame(0, 0, -1, 1'b0);

        clear_ram();
        o_re[0] = 32'sd1000;
        run_frame(0, 0, -1, 1'b0);

        clear_ram();
        o_re[8] = 32'sd1000;
        run_frame(0, 0, -1, 1'b0);

        clear_ram();
        e_re[0] = 32'sh7FFF_FFF0;
        o_re[0] = 32'sh0000_0100;
        run_frame(0, 0, -1, 1'b0);

        passthrough_ram();
        run_frame(12, 5, -1, 1'b1);

        random_ram(2);
        run_frame(0, 0, 11, 1'b0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        prev_ovf = 1'b0;

        passthrough_ram();
        run_frame(0, 0, -1, 1'b0);

        for (int f = 0; f < 3; f++) begin
            random_ram(f);
            run_frame(int'($urandom_range(30, 5)), int'($urandom_range(4, 1)), -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
